// File: rtl/mmio_uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_ctrl_pkg
//  Purpose  : Shared definitions for the Riscv151 MMIO UART controller.
//             Holds the register offsets, the status bit positions and the
//             address-region select value.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mmio_uart_ctrl_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [31:0] MMIO_STATUS = 32'h0000_0000;
    localparam logic [31:0] MMIO_RX     = 32'h0000_0004;
    localparam logic [31:0] MMIO_TX     = 32'h0000_0008;
    localparam logic [31:0] MMIO_CYC    = 32'h0000_0010;
    localparam logic [31:0] MMIO_INST   = 32'h0000_0014;
    localparam logic [31:0] MMIO_CRST   = 32'h0000_0018;

    // Status register bit positions
    localparam int STAT_TX_NFULL   = 0;
    localparam int STAT_RX_NEMPTY  = 1;
    localparam int STAT_TX_OVF     = 2;
    localparam int STAT_RX_OCC_LSB = 8;

    // addr[31:28] value that selects the MMIO region
    localparam logic [3:0] MMIO_REGION = 4'h8;

endpackage : mmio_uart_ctrl_pkg
`default_nettype wire

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO with occupancy count.
//             Push and pop in the same cycle are both honoured; a push into a
//             full FIFO is accepted only when a pop happens in that cycle, and
//             a pop from an empty FIFO is ignored.
//  Ports    : clk, rst_n (sync, active-low)
//             i_push/i_data  - write side
//             i_pop          - read side, o_data shows the head combinationally
//             o_full/o_empty - status, o_count - occupancy (0..DEPTH)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/mmio_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_ctrl
//  Purpose  : MMIO controller for the Riscv151: RX/TX byte FIFOs toward the
//             UART, cycle and retired-instruction counters, sticky TX overflow.
//             Read data is registered (one-cycle latency like dmem).
//  Ports    : clk, rst_n (sync, active-low)
//             addr/sel/re/we/wdata -> rdata   - core access port
//             inst_retired                    - retired-instruction pulse
//             rx_data/rx_valid/rx_ready       - from uart_receiver
//             tx_data/tx_valid/tx_ready       - to uart_transmitter
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_ctrl
    import mmio_uart_ctrl_pkg::*;
#(
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8,
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        sel,
    input  logic        re,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    logic [31:0]          w_off;
    logic                 w_hit;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_rd_fx;
    logic                 w_rx_pop;
    logic                 w_rx_push;
    logic [7:0]           w_rx_head;
    logic                 w_rx_full;
    logic                 w_rx_empty;
    logic [RX_AW:0]       w_rx_count;
    logic [31:0]          w_rx_cnt32;
    logic [3:0]           w_rx_occ;
    logic                 w_tx_push;
    logic                 w_tx_pop;
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic [TX_AW:0]       w_tx_count;
    logic                 w_cnt_clr;
    logic [31:0]          w_status;
    logic [31:0]          w_rdata_nxt;
    logic                 w_unused;
    logic                 r_tx_ovf;
    logic [CNT_WIDTH-1:0] r_cyc;
    logic [CNT_WIDTH-1:0] r_inst;
    logic [31:0]          r_rdata;

    assign w_off = addr - BASE_ADDR;
    assign w_hit = sel && (addr[31:28] == MMIO_REGION);
    assign w_wr  = w_hit && (we != 4'b0000);
    assign w_rd  = w_hit && re;
    // A simultaneous write wins: read side effects (pop, overflow clear)
    // are suppressed, though rdata is still captured.
    assign w_rd_fx = w_rd && !w_wr;

    // ---------------- RX path ----------------
    assign w_rx_pop  = w_rd_fx && (w_off == MMIO_RX) && !w_rx_empty;
    // A pop in this cycle frees a slot, so a full FIFO can still take the
    // receiver's byte; otherwise ready tracks "not full".
    assign rx_ready  = !w_rx_full || w_rx_pop;
    assign w_rx_push = rx_valid && rx_ready;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rx_push),
        .i_data  (rx_data),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    assign w_rx_cnt32 = 32'(w_rx_count);
    assign w_rx_occ   = (w_rx_cnt32 > 32'd15) ? 4'hF : w_rx_cnt32[3:0];

    // ---------------- TX path ----------------
    assign w_tx_push = w_wr && (w_off == MMIO_TX) && we[0];
    assign tx_valid  = !w_tx_empty;
    assign w_tx_pop  = tx_valid && tx_ready;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_tx_push),
        .i_data  (wdata[7:0]),
        .i_pop   (w_tx_pop),
        .o_data  (tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    // A write to a full FIFO is dropped unless the transmitter drains a
    // byte in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_ovf <= 1'b0;
        end else if (w_tx_push && w_tx_full && !w_tx_pop) begin
            r_tx_ovf <= 1'b1;
        end else if (w_rd_fx && (w_off == MMIO_STATUS)) begin
            r_tx_ovf <= 1'b0;
        end
    end

    // ---------------- Counters ----------------
    assign w_cnt_clr = w_wr && (w_off == MMIO_CRST);

    always_ff @(posedge clk) begin
        if (!rst_n || w_cnt_clr) begin
            r_cyc  <= '0;
            r_inst <= '0;
        end else begin
            r_cyc <= r_cyc + 1'b1;
            if (inst_retired) r_inst <= r_inst + 1'b1;
        end
    end

    // ---------------- Read data ----------------
    always_comb begin
        w_status                                     = 32'h0;
        w_status[STAT_TX_NFULL]                      = !w_tx_full;
        w_status[STAT_RX_NEMPTY]                     = !w_rx_empty;
        w_status[STAT_TX_OVF]                        = r_tx_ovf;
        w_status[STAT_RX_OCC_LSB+3:STAT_RX_OCC_LSB]  = w_rx_occ;
    end

    always_comb begin
        w_rdata_nxt = 32'h0;
        case (w_off)
            MMIO_STATUS: w_rdata_nxt = w_status;
            MMIO_RX:     w_rdata_nxt = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            MMIO_CYC:    w_rdata_nxt = 32'(r_cyc);
            MMIO_INST:   w_rdata_nxt = 32'(r_inst);
            default:     w_rdata_nxt = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 32'h0;
        end else if (w_rd) begin
            r_rdata <= w_rdata_nxt;
        end
    end

    assign rdata = r_rdata;

    assign w_unused = ^{wdata[31:8], w_tx_count};

endmodule : mmio_uart_ctrl
`default_nettype wire

// File: tb/tb_mmio_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_uart_ctrl
//  Purpose  : Directed self-checking bench for mmio_uart_ctrl.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        sel = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        inst_retired = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd_val;

    // Small counter width keeps the wrap check short.
    mmio_uart_ctrl #(
        .RX_DEPTH (8),
        .TX_DEPTH (8),
        .CNT_WIDTH(8),
        .BASE_ADDR(BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .sel          (sel),
        .re           (re),
        .we           (we),
        .wdata        (wdata),
        .rdata        (rdata),
        .inst_retired (inst_retired),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_wr(input logic [31:0] off, input logic [31:0] d);
        addr = BASE + off; sel = 1'b1; we = 4'hF; wdata = d;
        step();
        sel = 1'b0; we = 4'h0;
    endtask

    task automatic mmio_rd(input logic [31:0] off, output logic [31:0] d);
        addr = BASE + off; sel = 1'b1; re = 1'b1;
        step();
        sel = 1'b0; re = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_tx_ready();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        // ---- 1: reset state ----
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        mmio_rd(32'h00, rd_val);
        chk("rst_status", rd_val, 32'h0000_0001);

        // ---- 2: TX basic ----
        mmio_wr(32'h08, 32'hFFFF_FF41);
        mmio_wr(32'h08, 32'h0000_0042);
        chk("tx_valid_after_wr", {31'h0, tx_valid}, 32'h1);
        chk("tx_head_41", {24'h0, tx_data}, 32'h41);
        pulse_tx_ready();
        chk("tx_head_42", {24'h0, tx_data}, 32'h42);
        pulse_tx_ready();
        chk("tx_empty", {31'h0, tx_valid}, 32'h0);

        // ---- 3: TX overflow ----
        for (int i = 0; i < 9; i++) mmio_wr(32'h08, 32'h50 + i);
        mmio_rd(32'h00, rd_val);
        chk("ovf_status_set", rd_val, 32'h0000_0004);
        mmio_rd(32'h00, rd_val);
        chk("ovf_status_clr", rd_val, 32'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'h0, tx_valid}, 32'h1);
            chk("drain_byte", {24'h0, tx_data}, 32'h50 + i);
            pulse_tx_ready();
        end
        chk("drain_done", {31'h0, tx_valid}, 32'h0);

        // ---- 4: RX fill, pop+push on full, drain, empty read ----
        for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
        chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        mmio_rd(32'h00, rd_val);
        chk("rx_full_status", rd_val, 32'h0000_0803);
        rx_valid = 1'b1; rx_data = 8'h18;
        addr = BASE + 32'h04; sel = 1'b1; re = 1'b1;
        #1;
        chk("rx_ready_on_pop", {31'h0, rx_ready}, 32'h1);
        step();
        sel = 1'b0; re = 1'b0; rx_valid = 1'b0;
        chk("rx_pop_full", rdata, 32'h10);
        mmio_rd(32'h00, rd_val);
        chk("rx_still_8", rd_val, 32'h0000_0803);
        for (int i = 1; i < 9; i++) begin
            mmio_rd(32'h04, rd_val);
            chk("rx_drain", rd_val, 32'h10 + i);
        end
        mmio_rd(32'h04, rd_val);
        chk("rx_empty_read", rd_val, 32'h0);
        mmio_rd(32'h00, rd_val);
        chk("rx_no_underflow", rd_val, 32'h0000_0001);
        mmio_rd(32'h0C, rd_val);
        chk("unmapped_read", rd_val, 32'h0);

        // ---- 5: counters ----
        mmio_wr(32'h18, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i < 37);
            step();
        end
        inst_retired = 1'b0;
        mmio_rd(32'h10, rd_val);
        chk("cyc_100", rd_val, 32'd100);
        mmio_rd(32'h14, rd_val);
        chk("inst_37", rd_val, 32'd37);
        mmio_wr(32'h18, 32'h1);
        mmio_rd(32'h14, rd_val);
        chk("inst_cleared", rd_val, 32'd0);
        repeat (254) step();
        mmio_rd(32'h10, rd_val);
        chk("cyc_max", rd_val, 32'd255);
        mmio_rd(32'h10, rd_val);
        chk("cyc_wrap", rd_val, 32'd0);

        // ---- 6: reset mid-operation ----
        inst_retired = 1'b1;
        for (int i = 0; i < 4; i++) mmio_wr(32'h08, 32'hA0 + i);
        for (int i = 0; i < 4; i++) rx_push(8'hC0 + 8'(i));
        mmio_wr(32'h08, 32'hA4);
        for (int i = 0; i < 5; i++) mmio_wr(32'h08, 32'hB0 + i);
        inst_retired = 1'b0;
        mmio_rd(32'h00, rd_val);
        chk("pre_rst_status", rd_val, 32'h0000_0406);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("post_rst_rdata", rdata, 32'h0);
        chk("post_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("post_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        mmio_rd(32'h10, rd_val);
        chk("post_rst_cyc", rd_val, 32'd0);
        mmio_rd(32'h14, rd_val);
        chk("post_rst_inst", rd_val, 32'd0);
        mmio_rd(32'h00, rd_val);
        chk("post_rst_status", rd_val, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_mmio_uart_ctrl
`default_nettype wire
